// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the write-back stage: instruction class codes,
// load width selectors (funct3) and the FSM state encoding.
package writeback_unit_pkg;

  // Instruction class codes carried on itype_i
  localparam logic [4:0] IT_RTYPE  = 5'd0;
  localparam logic [4:0] IT_ITYPE  = 5'd1;
  localparam logic [4:0] IT_STYPE  = 5'd2;
  localparam logic [4:0] IT_BTYPE  = 5'd3;
  localparam logic [4:0] IT_LTYPE  = 5'd4;
  localparam logic [4:0] IT_UTYPE  = 5'd5;
  localparam logic [4:0] IT_JTYPE  = 5'd6;
  localparam logic [4:0] IT_JRTYPE = 5'd7;

  // Load width / sign selectors
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Width of the load-wait watchdog counter (timeouts up to 255 cycles)
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_WAIT = 3'd1,
    ST_COMMIT    = 3'd2,
    ST_RETIRE    = 3'd3,
    ST_ERROR     = 3'd4
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Bus between the retiring pipeline stage / memory and the write-back unit,
// plus the register-file write-back outputs consumed by decode.
//   master : upstream side (drives instruction, memory response; sees results)
//   slave  : writeback_unit side
// Signals:
//   valid_i, itype_i[4:0], funct3_i[2:0], rd_i[4:0], alu_res_i[31:0], pc_i[31:0]
//   mem_rdata_i[31:0], mem_rvalid_i
//   ready_o, wd_o[31:0], wd_rd_o[4:0], wd_q_o, done_o, err_o
interface writeback_unit_if;
  logic        valid_i;
  logic [4:0]  itype_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_res_i;
  logic [31:0] pc_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        ready_o;
  logic [31:0] wd_o;
  logic [4:0]  wd_rd_o;
  logic        wd_q_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output valid_i, itype_i, funct3_i, rd_i, alu_res_i, pc_i,
           mem_rdata_i, mem_rvalid_i,
    input  ready_o, wd_o, wd_rd_o, wd_q_o, done_o, err_o
  );

  modport slave (
    input  valid_i, itype_i, funct3_i, rd_i, alu_res_i, pc_i,
           mem_rdata_i, mem_rvalid_i,
    output ready_o, wd_o, wd_rd_o, wd_q_o, done_o, err_o
  );
endinterface

// File: rtl/writeback_unit_load_extract.sv
// Combinational load lane select with sign/zero extension.
// Ports:
//   funct3_i[2:0]  load width/sign selector
//   addr_i[1:0]    byte offset of the effective address
//   rdata_i[31:0]  word-aligned memory read data
//   data_o[31:0]   extracted, extended load value
//   misalign_o     halfword not 2-aligned, or word not 4-aligned
//   illegal_o      funct3 is not a load encoding
module writeback_unit_load_extract
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = sext8(byte_sel);
      F3_LBU: data_o = {24'd0, byte_sel};
      F3_LH: begin
        data_o     = sext16(half_sel);
        misalign_o = addr_i[0];
      end
      F3_LHU: begin
        data_o     = {16'd0, half_sel};
        misalign_o = addr_i[0];
      end
      F3_LW: begin
        data_o     = rdata_i;
        misalign_o = (addr_i != 2'd0);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects the retiring result (ALU, link address or
// extended load data) and drives the register-file write-back port.
// Loads wait for memory data under a watchdog; bad loads and timeouts
// produce an err_o pulse instead of a write.
// Ports:
//   clk    core clock
//   reset  synchronous, active-high
//   wb     writeback_unit_if.slave (instruction in, memory response in,
//          ready_o / wd_o / wd_rd_o / wd_q_o / done_o / err_o out)
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter logic [31:0] RESET_PC_INC = 32'd4
) (
  input  logic            clk,
  input  logic            reset,
  writeback_unit_if.slave wb
);

  // Last LOAD_WAIT counter value before the watchdog fires.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state_q;
  logic             ready_q;
  logic [31:0]      wd_data_q;
  logic [4:0]       wd_rd_q;
  logic             wd_stb_q;
  logic             done_q;
  logic             err_q;
  logic [TMO_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       addr_q;

  logic [2:0]  ext_f3;
  logic [1:0]  ext_addr;
  logic [31:0] ext_data;
  logic        ext_misalign;
  logic        ext_illegal;

  // One extractor serves both uses: in IDLE it checks the incoming load's
  // legality; afterwards it extracts using the captured funct3/offset.
  assign ext_f3   = (state_q == ST_IDLE) ? wb.funct3_i       : f3_q;
  assign ext_addr = (state_q == ST_IDLE) ? wb.alu_res_i[1:0] : addr_q;

  writeback_unit_load_extract u_extract (
    .funct3_i   (ext_f3),
    .addr_i     (ext_addr),
    .rdata_i    (wb.mem_rdata_i),
    .data_o     (ext_data),
    .misalign_o (ext_misalign),
    .illegal_o  (ext_illegal)
  );

  // Outputs are registered alongside the state transition so each pulse
  // lines up with the cycle spent in COMMIT/RETIRE/ERROR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      wd_data_q <= '0;
      wd_rd_q   <= '0;
      wd_stb_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      f3_q      <= '0;
      addr_q    <= '0;
    end else begin
      wd_stb_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wb.valid_i) begin
            ready_q <= 1'b0;
            wd_rd_q <= wb.rd_i;
            f3_q    <= wb.funct3_i;
            addr_q  <= wb.alu_res_i[1:0];
            case (wb.itype_i)
              IT_RTYPE, IT_ITYPE, IT_UTYPE: begin
                wd_data_q <= wb.alu_res_i;
                wd_stb_q  <= (wb.rd_i != 5'd0);
                done_q    <= 1'b1;
                state_q   <= ST_COMMIT;
              end
              IT_JTYPE, IT_JRTYPE: begin
                wd_data_q <= wb.pc_i + RESET_PC_INC;
                wd_stb_q  <= (wb.rd_i != 5'd0);
                done_q    <= 1'b1;
                state_q   <= ST_COMMIT;
              end
              IT_LTYPE: begin
                if (ext_illegal || ext_misalign) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_ERROR;
                end else begin
                  cnt_q   <= '0;
                  state_q <= ST_LOAD_WAIT;
                end
              end
              default: begin
                // Stores, branches and unknown classes retire without a write.
                done_q  <= 1'b1;
                state_q <= ST_RETIRE;
              end
            endcase
          end
        end
        ST_LOAD_WAIT: begin
          // Data arriving on the watchdog's final cycle still commits.
          if (wb.mem_rvalid_i) begin
            wd_data_q <= ext_data;
            wd_stb_q  <= (wd_rd_q != 5'd0);
            done_q    <= 1'b1;
            state_q   <= ST_COMMIT;
          end else if (cnt_q == TMO_LAST) begin
            cnt_q   <= cnt_q + TMO_W'(1);
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_ERROR;
          end else begin
            cnt_q <= cnt_q + TMO_W'(1);
          end
        end
        default: begin
          // COMMIT, RETIRE and ERROR last exactly one cycle; this also keeps
          // wd_q_o from ever being high on consecutive cycles.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wb.ready_o = ready_q;
  assign wb.wd_o    = wd_data_q;
  assign wb.wd_rd_o = wd_rd_q;
  assign wb.wd_q_o  = wd_stb_q;
  assign wb.done_o  = done_q;
  assign wb.err_o   = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int unsigned T   = 16;
  localparam logic [31:0] INC = 32'd4;
  localparam int K_WRITE  = 0;
  localparam int K_RETIRE = 1;
  localparam int K_ERR    = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  writeback_unit_if bus();

  writeback_unit #(.LOAD_TIMEOUT(T), .RESET_PC_INC(INC)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.ready_o, bus.wd_q_o, bus.done_o, bus.err_o};
  endfunction

  // Reference: which loads are legal for a given width and byte offset.
  function automatic bit load_ok(input logic [2:0] f3, input int a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return a == 0;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference: loaded value by shifting the word down and masking.
  function automatic logic [31:0] load_val(input logic [2:0] f3, input int a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'h0000_00FF;
    h = (w >> (8 * a)) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic junk_fields();
    bus.itype_i   = 5'($urandom_range(0, 7));
    bus.funct3_i  = 3'($urandom_range(0, 7));
    bus.rd_i      = 5'($urandom_range(0, 31));
    bus.alu_res_i = $urandom;
    bus.pc_i      = $urandom;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // of the first idle cycle after the transaction.
  // d: cycle (counted from accept) on which mem_rvalid_i is raised, 0 = never.
  task automatic run_txn(input string tag, input logic [4:0] it, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] rdata, input int d);
    int          kind, fin, a;
    logic [31:0] expwd;
    bit          is_load, good_load;
    a         = int'(alu[1:0]);
    is_load   = (it == IT_LTYPE);
    good_load = is_load && load_ok(f3, a);
    expwd     = '0;
    if (is_load) begin
      if (!good_load)           begin kind = K_ERR;   fin = 1; end
      else if (d >= 1 && d <= T) begin kind = K_WRITE; fin = d + 1; expwd = load_val(f3, a, rdata); end
      else                      begin kind = K_ERR;   fin = T + 1; end
    end else if (it == IT_RTYPE || it == IT_ITYPE || it == IT_UTYPE) begin
      kind = K_WRITE; fin = 1; expwd = alu;
    end else if (it == IT_JTYPE || it == IT_JRTYPE) begin
      kind = K_WRITE; fin = 1; expwd = pc + INC;
    end else begin
      kind = K_RETIRE; fin = 1;
    end

    chk({tag, "/ready"}, 32'(bus.ready_o), 32'd1);
    bus.valid_i      = 1'b1;
    bus.itype_i      = it;
    bus.funct3_i     = f3;
    bus.rd_i         = rd;
    bus.alu_res_i    = alu;
    bus.pc_i         = pc;
    bus.mem_rdata_i  = $urandom;
    bus.mem_rvalid_i = 1'($urandom_range(0, 1));
    @(negedge clk);

    for (int c = 1; c <= fin + 1; c++) begin
      if (c < fin) begin
        chk({tag, "/busy"}, 32'(flags()), 32'(4'b0000));
      end else if (c == fin) begin
        chk({tag, "/end"}, 32'(flags()),
            32'({1'b0, (kind == K_WRITE) && (rd != 5'd0), 1'b1, kind == K_ERR}));
        if (kind == K_WRITE) begin
          chk({tag, "/wd"}, bus.wd_o, expwd);
          chk({tag, "/wd_rd"}, 32'(bus.wd_rd_o), 32'(rd));
        end
      end else begin
        chk({tag, "/idle"}, 32'(flags()), 32'(4'b1000));
        if (kind == K_WRITE) chk({tag, "/wd_hold"}, bus.wd_o, expwd);
      end
      if (c <= fin) begin
        bus.valid_i = 1'($urandom_range(0, 1));
        junk_fields();
        if (good_load) begin
          bus.mem_rvalid_i = (c == d);
          bus.mem_rdata_i  = (c == d) ? rdata : $urandom;
        end else begin
          bus.mem_rvalid_i = 1'($urandom_range(0, 1));
          bus.mem_rdata_i  = $urandom;
        end
        @(negedge clk);
      end else begin
        bus.valid_i      = 1'b0;
        bus.mem_rvalid_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [4:0]  it;
    logic [2:0]  f3;
    logic [31:0] alu;
    int          d;

    reset            = 1'b1;
    bus.valid_i      = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    junk_fields();
    @(negedge clk);
    @(negedge clk);
    chk("rst/flags", 32'(flags()), 32'(4'b1000));
    chk("rst/wd", bus.wd_o, 32'd0);
    chk("rst/wd_rd", 32'(bus.wd_rd_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn("rtype",   IT_RTYPE,  3'd0, 5'd5, 32'h0000_1234, 32'h0,         32'h0,         0);
    run_txn("rtype2",  IT_RTYPE,  3'd0, 5'd6, 32'hDEAD_BEEF, 32'h0,         32'h0,         0);
    run_txn("lb",      IT_LTYPE,  3'd0, 5'd7, 32'h1000_0003, 32'h0,         32'h80FF_FF7F, 3);
    run_txn("lbu",     IT_LTYPE,  3'd4, 5'd7, 32'h1000_0003, 32'h0,         32'h80FF_FF7F, 3);
    run_txn("lh_mis",  IT_LTYPE,  3'd1, 5'd8, 32'h1000_0001, 32'h0,         32'h1234_5678, 1);
    run_txn("lw_mis",  IT_LTYPE,  3'd2, 5'd8, 32'h1000_0002, 32'h0,         32'h1234_5678, 1);
    run_txn("ld_ill",  IT_LTYPE,  3'd3, 5'd8, 32'h1000_0000, 32'h0,         32'h1234_5678, 1);
    run_txn("lh_hi",   IT_LTYPE,  3'd1, 5'd9, 32'h1000_0002, 32'h0,         32'h8001_7FFF, 1);
    run_txn("lhu_hi",  IT_LTYPE,  3'd5, 5'd9, 32'h1000_0002, 32'h0,         32'h8001_7FFF, 2);
    run_txn("jal",     IT_JTYPE,  3'd0, 5'd1, 32'h0,         32'hFFFF_FFFC, 32'h0,         0);
    run_txn("jalr_r0", IT_JRTYPE, 3'd0, 5'd0, 32'h0,         32'h0000_0100, 32'h0,         0);
    run_txn("lw_tmo",  IT_LTYPE,  3'd2, 5'd3, 32'h2000_0000, 32'h0,         32'hCAFE_F00D, 0);
    run_txn("lw_last", IT_LTYPE,  3'd2, 5'd3, 32'h2000_0000, 32'h0,         32'hCAFE_F00D, T);
    run_txn("lw_late", IT_LTYPE,  3'd2, 5'd3, 32'h2000_0000, 32'h0,         32'hCAFE_F00D, T + 1);
    run_txn("store",   IT_STYPE,  3'd2, 5'd4, 32'h3000_0000, 32'h0,         32'h0,         0);
    run_txn("branch",  IT_BTYPE,  3'd0, 5'd4, 32'h3000_0000, 32'h0,         32'h0,         0);
    run_txn("utype",   IT_UTYPE,  3'd0, 5'd0, 32'h1234_5000, 32'h0,         32'h0,         0);

    for (int i = 0; i < 150; i++) begin
      it  = ($urandom_range(0, 2) == 0) ? IT_LTYPE : 5'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'd0;
      d   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T + 2));
      run_txn("rand", it, f3, 5'($urandom_range(0, 31)), alu, $urandom, $urandom, d);
    end

    // Reset during LOAD_WAIT with data arriving on the same edge.
    bus.valid_i      = 1'b1;
    bus.itype_i      = IT_LTYPE;
    bus.funct3_i     = 3'd2;
    bus.rd_i         = 5'd12;
    bus.alu_res_i    = 32'h4000_0000;
    bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rstmid/wait", 32'(flags()), 32'(4'b0000));
      @(negedge clk);
    end
    reset            = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstmid/flags", 32'(flags()), 32'(4'b1000));
    chk("rstmid/wd", bus.wd_o, 32'd0);
    chk("rstmid/wd_rd", 32'(bus.wd_rd_o), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid/after", 32'(flags()), 32'(4'b1000));
    end
    bus.mem_rvalid_i = 1'b0;
    run_txn("post_rst", IT_RTYPE, 3'd0, 5'd31, 32'h0BAD_F00D, 32'h0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
